// File: rtl/pdm_byte_streamer.sv
// PDM-to-PCM byte streamer: ones-count decimation, byte FIFO and serial-tx handshake.
// Optional build macro PDM_SYNC_EN adds 8'hFF frame sync bytes and clamps samples to 8'hFE.
module pdm_byte_streamer #(
   parameter int DECIM_LOG2     = 6,
   parameter int FIFO_LOG2      = 4,
   parameter int SAMPLE_ON_RISE = 1,
   parameter int FRAME_LEN      = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pdm_clk,
   input  logic               pdm_data,
   input  logic               enable,
   output logic [7:0]         tx_data,
   output logic               new_tx_data,
   input  logic               tx_busy,
   output logic               overflow,
   output logic [FIFO_LOG2:0] fifo_level
);

   localparam int DEPTH = 1 << FIFO_LOG2;
   localparam logic [DECIM_LOG2:0] FULL_ONES  = {1'b1, {DECIM_LOG2{1'b0}}};
   localparam logic [FIFO_LOG2:0]  LEVEL_FULL = {1'b1, {FIFO_LOG2{1'b0}}};

   generate
      if (DECIM_LOG2 < 1 || DECIM_LOG2 > 8 || FRAME_LEN < 1) begin : g_param_check
         $error("pdm_byte_streamer: DECIM_LOG2 must be 1..8 and FRAME_LEN at least 1");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, SEND, HOLD, WAIT} state_t;
   state_t state_reg, state_next;

   logic [1:0]            pdm_clk_sync_reg, pdm_data_sync_reg;
   logic                  pdm_clk_prev_reg;
   logic                  pdm_clk_s, pdm_bit, bit_strobe;
   logic [DECIM_LOG2-1:0] bit_cnt_reg;
   logic [DECIM_LOG2:0]   ones_reg, ones_sum;
   logic [7:0]            scaled, sample_value, sample_reg;
   logic                  sample_valid_reg;
   logic [7:0]            mem [DEPTH];
   logic [FIFO_LOG2-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [FIFO_LOG2:0]    level_reg;
   logic                  overflow_reg, fifo_full, fifo_empty;
   logic                  wr_req, wr_en, room_ok, drop, pop;
   logic [7:0]            wr_byte, tx_data_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pdm_clk_sync_reg  <= '0;
         pdm_data_sync_reg <= '0;
         pdm_clk_prev_reg  <= 1'b0;
      end else begin
         pdm_clk_sync_reg  <= {pdm_clk_sync_reg[0], pdm_clk};
         pdm_data_sync_reg <= {pdm_data_sync_reg[0], pdm_data};
         pdm_clk_prev_reg  <= pdm_clk_sync_reg[1];
      end
   end

   assign pdm_clk_s  = pdm_clk_sync_reg[1];
   assign pdm_bit    = pdm_data_sync_reg[1];
   assign bit_strobe = (SAMPLE_ON_RISE != 0) ? (pdm_clk_s & ~pdm_clk_prev_reg)
                                             : (~pdm_clk_s & pdm_clk_prev_reg);

   // The bit that wraps bit_cnt is the last bit of its window, so each sample covers exactly 2^DECIM_LOG2 bits.
   assign ones_sum = ones_reg + {{DECIM_LOG2{1'b0}}, pdm_bit};

   generate
      if (DECIM_LOG2 >= 8) begin : g_no_shift
         assign scaled = ones_sum[7:0];
      end else begin : g_shift
         assign scaled = {ones_sum[DECIM_LOG2-1:0], {(8-DECIM_LOG2){1'b0}}};
      end
   endgenerate

   always_comb begin
      sample_value = (ones_sum == FULL_ONES) ? 8'hFF : scaled;
`ifdef PDM_SYNC_EN
      if (sample_value == 8'hFF) sample_value = 8'hFE;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_reg      <= '0;
         ones_reg         <= '0;
         sample_reg       <= '0;
         sample_valid_reg <= 1'b0;
      end else begin
         sample_valid_reg <= 1'b0;
         if (!enable) begin
            bit_cnt_reg <= '0;
            ones_reg    <= '0;
         end else if (bit_strobe) begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == '1) begin
               ones_reg         <= '0;
               sample_reg       <= sample_value;
               sample_valid_reg <= 1'b1;
            end else begin
               ones_reg <= ones_sum;
            end
         end
      end
   end

   assign fifo_full  = (level_reg == LEVEL_FULL);
   assign fifo_empty = (level_reg == '0);

`ifdef PDM_SYNC_EN
   localparam int SYNC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [SYNC_W-1:0]  SYNC_LAST = SYNC_W'(FRAME_LEN - 1);
   localparam logic [FIFO_LOG2:0] SYNC_ROOM = LEVEL_FULL - 2'd2;
   logic [SYNC_W-1:0] sync_cnt_reg;
   logic              sync_pend_reg, sync_set, sync_adv;
`endif

   // Sync builds write the 8'hFF first and hold the sample back for one cycle.
   always_comb begin
      wr_req  = sample_valid_reg;
      wr_byte = sample_reg;
      room_ok = !fifo_full || pop;
`ifdef PDM_SYNC_EN
      sync_set = 1'b0;
      sync_adv = 1'b0;
      if (sync_pend_reg) begin
         wr_req   = 1'b1;
         sync_adv = 1'b1;
      end else if (sample_valid_reg && sync_cnt_reg == '0) begin
         if (level_reg <= SYNC_ROOM) begin
            wr_byte  = 8'hFF;
            sync_set = 1'b1;
         end else begin
            room_ok = 1'b0;
         end
      end else if (sample_valid_reg && room_ok) begin
         sync_adv = 1'b1;
      end
`endif
      wr_en = wr_req && room_ok;
      drop  = wr_req && !room_ok;
   end

`ifdef PDM_SYNC_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_cnt_reg  <= '0;
         sync_pend_reg <= 1'b0;
      end else begin
         sync_pend_reg <= sync_set;
         if (sync_adv) sync_cnt_reg <= (sync_cnt_reg == SYNC_LAST) ? '0 : sync_cnt_reg + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_reg] <= wr_byte;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         overflow_reg <= 1'b0;
         tx_data_reg  <= '0;
      end else begin
         if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop) begin
            rd_ptr_reg  <= rd_ptr_reg + 1'b1;
            tx_data_reg <= mem[rd_ptr_reg];
         end
         if (wr_en && !pop)      level_reg <= level_reg + 1'b1;
         else if (!wr_en && pop) level_reg <= level_reg - 1'b1;
         if (drop) overflow_reg <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // SEND presents the byte popped in IDLE; HOLD covers the tx's one-cycle busy latency.
   always_comb begin
      state_next = state_reg;
      pop        = 1'b0;
      case (state_reg)
         IDLE: if (!fifo_empty && !tx_busy) begin
            pop        = 1'b1;
            state_next = SEND;
         end
         SEND: state_next = HOLD;
         HOLD: state_next = WAIT;
         WAIT: if (!tx_busy) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign tx_data     = tx_data_reg;
   assign new_tx_data = (state_reg == SEND);
   assign overflow    = overflow_reg;
   assign fifo_level  = level_reg;

endmodule
